clk_div_prog: RTL and testbench

Programmable, parametrised clock-enable/divider generator for slow board-level timing such as LED blink, display refresh and debounce sampling. It divides speed_clock by a run-time loadable ratio. It produces a 50% square wave (low_clock) and a one-cycle strobe (tick) at every terminal count. New ratios are applied glitch-free at period boundaries, with a load acknowledge.

---
 rtl/clk_div_prog_if.sv | 26 ++
 rtl/clk_div_prog.sv | 108 ++++++++++
 tb/tb_clk_div_prog.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/clk_div_prog_if.sv
// Control/status bundle for the programmable clock divider.
// The master drives enable, clear and divisor loads; the slave (the divider)
// returns the divided clock, strobes and the live counter value.
interface clk_div_prog_if #(
  parameter int WIDTH = 27
);
  logic             enable;
  logic             sync_clr;
  logic [WIDTH-1:0] div_value;
  logic             div_load;
  logic             load_ack;
  logic             load_err;
  logic             low_clock;
  logic             tick;
  logic [WIDTH-1:0] count;

  modport master (
    output enable, sync_clr, div_value, div_load,
    input  load_ack, load_err, low_clock, tick, count
  );

  modport slave (
    input  enable, sync_clr, div_value, div_load,
    output load_ack, load_err, low_clock, tick, count
  );
endinterface

// File: rtl/clk_div_prog.sv
// Programmable clock divider / clock-enable generator.
// div_r holds the half-period of low_clock in speed_clock cycles. New divisors
// are captured into a shadow register and only take effect at a period
// boundary (terminal count), or immediately when counting is disabled, so
// low_clock never produces a runt pulse.
module clk_div_prog #(
  parameter int WIDTH       = 27,
  parameter int DEFAULT_DIV = 25000000
) (
  input  logic                speed_clock,
  input  logic                reset,
  clk_div_prog_if.slave       bus
);

  localparam logic [WIDTH-1:0] DIV_INIT = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};

  logic [WIDTH-1:0] cont_r,    cont_s;
  logic [WIDTH-1:0] div_r,     div_s;
  logic [WIDTH-1:0] shadow_r,  shadow_s;
  logic             pending_r, pending_s;
  logic             low_r,     low_s;
  logic             tick_r,    tick_s;
  logic             ack_r,     ack_s;
  logic             err_r,     err_s;
  logic             terminal_s;
  logic             capture_s;

  // Next-state logic: sync_clr beats divisor apply, which beats normal counting;
  // load capture runs after the apply so a same-edge load re-arms pending.
  always_comb begin
    terminal_s = bus.enable && (cont_r == (div_r - ONE));
    capture_s  = bus.div_load && (bus.div_value != ZERO);
    cont_s     = cont_r;
    div_s      = div_r;
    shadow_s   = shadow_r;
    pending_s  = pending_r;
    low_s      = low_r;
    tick_s     = 1'b0;
    ack_s      = 1'b0;
    err_s      = bus.div_load && (bus.div_value == ZERO);

    if (bus.sync_clr) begin
      // Phase restart; a pending divisor waits for the next boundary.
      cont_s = ZERO;
      low_s  = 1'b0;
    end else if (terminal_s) begin
      cont_s = ZERO;
      low_s  = ~low_r;
      tick_s = 1'b1;
      if (pending_r) begin
        div_s     = shadow_r;
        pending_s = 1'b0;
        ack_s     = 1'b1;
      end else begin
        div_s     = div_r;
      end
    end else if (bus.enable) begin
      cont_s = cont_r + ONE;
    end else if (pending_r) begin
      // Frozen counter: no period in flight, so apply right away and restart.
      div_s     = shadow_r;
      cont_s    = ZERO;
      pending_s = 1'b0;
      ack_s     = 1'b1;
    end else begin
      cont_s = cont_r;
    end

    if (capture_s) begin
      shadow_s  = bus.div_value;
      pending_s = 1'b1;
    end else begin
      shadow_s  = shadow_r;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge speed_clock) begin
    if (!reset) begin
      cont_r    <= ZERO;
      div_r     <= DIV_INIT;
      shadow_r  <= ZERO;
      pending_r <= 1'b0;
      low_r     <= 1'b0;
      tick_r    <= 1'b0;
      ack_r     <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      cont_r    <= cont_s;
      div_r     <= div_s;
      shadow_r  <= shadow_s;
      pending_r <= pending_s;
      low_r     <= low_s;
      tick_r    <= tick_s;
      ack_r     <= ack_s;
      err_r     <= err_s;
    end
  end

  assign bus.count     = cont_r;
  assign bus.low_clock = low_r;
  assign bus.tick      = tick_r;
  assign bus.load_ack  = ack_r;
  assign bus.load_err  = err_r;

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog (WIDTH=8, DEFAULT_DIV=4). Stimulus pushes the
// expected strobe events (edge number, tick/ack/err, low_clock, count) into a
// queue; a monitor pops one entry whenever any strobe is seen and compares.
module tb_clk_div_prog;

  typedef struct packed {
    int unsigned at;
    logic        tick;
    logic        ack;
    logic        err;
    logic        low;
    logic [7:0]  cnt;
  } ev_t;

  logic        clk;
  logic        reset;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  ev_t         exp_q[$];

  clk_div_prog_if #(.WIDTH(8)) bus ();

  clk_div_prog #(.WIDTH(8), .DEFAULT_DIV(4)) dut (
    .speed_clock (clk),
    .reset       (reset),
    .bus         (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter: after edge N (and #1), cyc == N.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int unsigned at, input logic t, input logic a,
                      input logic e, input logic l, input logic [7:0] c);
    ev_t ev;
    ev.at = at; ev.tick = t; ev.ack = a; ev.err = e; ev.low = l; ev.cnt = c;
    exp_q.push_back(ev);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, got, exp, cyc);
  endtask

  task automatic run_to(input int unsigned c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: any strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.tick === 1'b1 || bus.load_ack === 1'b1 || bus.load_err === 1'b1) begin
      ev_t got;
      ev_t exp;
      got.at = cyc; got.tick = bus.tick; got.ack = bus.load_ack; got.err = bus.load_err;
      got.low = bus.low_clock; got.cnt = bus.count;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_event: edge %0d tick=%b ack=%b err=%b low=%b cnt=%0d, none expected",
                 got.at, got.tick, got.ack, got.err, got.low, got.cnt);
      end else begin
        exp = exp_q.pop_front();
        if (got === exp) n_pass++;
        else $display("FAIL event: got edge %0d t/a/e/l=%b%b%b%b cnt=%0d, expected edge %0d t/a/e/l=%b%b%b%b cnt=%0d",
                      got.at, got.tick, got.ack, got.err, got.low, got.cnt,
                      exp.at, exp.tick, exp.ack, exp.err, exp.low, exp.cnt);
      end
    end
  end

  initial begin
    reset         = 1'b0;
    bus.enable    = 1'b0;
    bus.sync_clr  = 1'b0;
    bus.div_load  = 1'b0;
    bus.div_value = 8'd0;

    // Reset held for three edges.
    run_to(3);
    chk("reset_count", 32'(bus.count), 32'd0);
    chk("reset_low", 32'(bus.low_clock), 32'd0);
    chk("reset_tick", 32'(bus.tick), 32'd0);
    chk("reset_ack", 32'(bus.load_ack), 32'd0);

    // Release and run at the default divisor 4: first rise on 4th enabled edge.
    reset = 1'b1;
    bus.enable = 1'b1;
    push(7, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0);
    push(11, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    push(15, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0);
    run_to(16);
    chk("count_runs", 32'(bus.count), 32'd1);

    // Freeze at count 2 for five edges; terminal two edges after re-enable.
    run_to(17);
    push(24, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    push(28, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0);
    bus.enable = 1'b0;
    run_to(22);
    chk("freeze_count", 32'(bus.count), 32'd2);
    chk("freeze_low", 32'(bus.low_clock), 32'd1);
    bus.enable = 1'b1;

    // Load 2 at count 1: old period completes, ack with tick, then period 4.
    run_to(29);
    bus.div_load = 1'b1;
    bus.div_value = 8'd2;
    push(32, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    push(34, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0);
    push(36, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    push(38, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0);
    run_to(30);
    bus.div_load = 1'b0;

    // Disabled load of 6: ack on the edge after capture, count 0, level held.
    run_to(39);
    bus.enable = 1'b0;
    run_to(40);
    bus.div_load = 1'b1;
    bus.div_value = 8'd6;
    push(42, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0);
    run_to(41);
    bus.div_load = 1'b0;
    run_to(43);
    bus.enable = 1'b1;
    push(49, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);

    // Zero divisor: error strobe only, period unchanged.
    run_to(50);
    bus.div_load = 1'b1;
    bus.div_value = 8'd0;
    push(51, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2);
    push(55, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0);
    run_to(51);
    bus.div_load = 1'b0;

    // Back-to-back loads 3 then 5: one ack, divisor 5 wins.
    run_to(56);
    bus.div_load = 1'b1;
    bus.div_value = 8'd3;
    run_to(57);
    bus.div_value = 8'd5;
    run_to(58);
    bus.div_load = 1'b0;
    push(61, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    push(66, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0);

    // Reset mid-period with a load pending: pending is discarded.
    run_to(67);
    bus.div_load = 1'b1;
    bus.div_value = 8'd7;
    run_to(68);
    bus.div_load = 1'b0;
    chk("pre_reset_count", 32'(bus.count), 32'd2);
    reset = 1'b0;
    run_to(69);
    chk("midreset_count", 32'(bus.count), 32'd0);
    chk("midreset_low", 32'(bus.low_clock), 32'd0);
    reset = 1'b1;
    push(73, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0);

    // sync_clr on what would be the terminal edge: no tick, phase restarts.
    run_to(76);
    bus.sync_clr = 1'b1;
    run_to(77);
    chk("sclr_count", 32'(bus.count), 32'd0);
    chk("sclr_low", 32'(bus.low_clock), 32'd0);
    chk("sclr_tick", 32'(bus.tick), 32'd0);
    bus.sync_clr = 1'b0;
    push(81, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0);

    // Divisor 1: tick every edge, low_clock toggles each cycle.
    run_to(82);
    bus.div_load = 1'b1;
    bus.div_value = 8'd1;
    run_to(83);
    bus.div_load = 1'b0;
    push(85, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    push(86, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0);
    push(87, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    push(88, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0);
    run_to(88);
    bus.enable = 1'b0;
    run_to(92);
    chk("div1_hold_low", 32'(bus.low_clock), 32'd1);

    chk("events_outstanding", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
